// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the two-requester data-memory arbiter.
// Requester ids, the registered response tag, and a helper to name the opposite requester.
package dmem_arb_pkg;

  localparam int DEF_AW        = 32;
  localparam int DEF_DW        = 32;
  localparam int DEF_BURST_MAX = 4;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
    logic    we;
  } rsp_tag_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_CORE) ? REQ_DBG : REQ_CORE;
  endfunction

endpackage

// File: rtl/rr2_burst_grant.sv
// Two-way round-robin arbiter with a bounded burst hold; produces a one-hot grant.
// The reset input is active-low; while it is low no grant is ever raised.
module rr2_burst_grant
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  localparam int CW = $clog2(BURST_MAX + 1);

  req_id_t       rr_q, rr_d;
  req_id_t       owner_q, owner_d;
  logic          owner_vld_q, owner_vld_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;

  req_id_t win;
  logic    win_vld;

  // Winner selection: a lone requester always wins; under contention the last owner keeps
  // the port until its contested streak reaches BURST_MAX.
  always_comb begin
    win     = rr_q;
    win_vld = 1'b0;
    if (reset) begin
      unique case (valid)
        2'b01: begin
          win     = REQ_CORE;
          win_vld = 1'b1;
        end
        2'b10: begin
          win     = REQ_DBG;
          win_vld = 1'b1;
        end
        2'b11: begin
          win_vld = 1'b1;
          if (!owner_vld_q) begin
            win = rr_q;
          end else if (burst_cnt_q < CW'(BURST_MAX)) begin
            win = owner_q;
          end else begin
            win = other_id(owner_q);
          end
        end
        default: ;
      endcase
    end
    grant = {win_vld & (win == REQ_DBG), win_vld & (win == REQ_CORE)};
  end

  // Uncontested beats leave the streak at zero so they never count against the owner.
  always_comb begin
    rr_d        = rr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    burst_cnt_d = burst_cnt_q;
    if (win_vld) begin
      rr_d        = other_id(win);
      owner_d     = win;
      owner_vld_d = 1'b1;
      if (valid != 2'b11) begin
        burst_cnt_d = '0;
      end else if (owner_vld_q && (owner_q == win)) begin
        if (burst_cnt_q != CW'(BURST_MAX)) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end else begin
        burst_cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= REQ_CORE;
      owner_q     <= REQ_CORE;
      owner_vld_q <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-memory port between the core lane (req0) and debug port (req1).
// Granted payload drives the memory in-cycle; a one-deep tag routes the response next cycle.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [DW/8-1:0] req0_wstrb,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [DW/8-1:0] req1_wstrb,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0] grant;
  rsp_tag_t   tag_q, tag_d;
  logic [DW-1:0] rsp_data;

  rr2_burst_grant #(
    .BURST_MAX(BURST_MAX)
  ) u_grant (
    .clk  (clk),
    .reset(reset),
    .valid({req1_valid, req0_valid}),
    .grant(grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Memory port carries the winner's payload; byte enables are forced low on reads.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant[0]) begin
      mem_en    = 1'b1;
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      mem_wstrb = req0_we ? req0_wstrb : '0;
    end else if (grant[1]) begin
      mem_en    = 1'b1;
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      mem_wstrb = req1_we ? req1_wstrb : '0;
    end
  end

  always_comb begin
    tag_d     = '0;
    tag_d.vld = mem_en;
    tag_d.id  = grant[1] ? REQ_DBG : REQ_CORE;
    tag_d.we  = mem_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Write acks return zero data; the idle response port is held at zero.
  always_comb begin
    rsp_data   = tag_q.we ? '0 : mem_rdata;
    rsp0_valid = tag_q.vld && (tag_q.id == REQ_CORE);
    rsp1_valid = tag_q.vld && (tag_q.id == REQ_DBG);
    rsp0_rdata = rsp0_valid ? rsp_data : '0;
    rsp1_rdata = rsp1_valid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a random phase,
// all compared against a rule-level arbitration and memory model held in the bench.
module tb_dmem_port_arbiter;

  localparam int BURST_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] env_w;

  int total = 0;
  int bad = 0;

  int          last_win;
  int          streak;
  logic        exp_rsp_vld;
  int          exp_rsp_id;
  logic [31:0] exp_rsp_data;
  int          last_g;
  logic        obs_mem_we, obs_rsp0_v, obs_rsp1_v;
  logic [3:0]  obs_mem_wstrb;
  logic [31:0] obs_rsp0_d, obs_rsp1_d;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(32), .DW(32), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_we(req_we[0]),
    .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]), .req0_wstrb(req_wstrb[0]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_we(req_we[1]),
    .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]), .req1_wstrb(req_wstrb[1]),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Synchronous memory the arbiter talks to.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        env_w = env_mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) env_w[8*b +: 8] = mem_wdata[8*b +: 8];
        env_mem[mem_addr[9:2]] <= env_w;
      end else begin
        mem_rdata <= env_mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    if (req_valid[0] && !req_valid[1]) return 0;
    if (req_valid[1] && !req_valid[0]) return 1;
    if (!req_valid[0]) return -1;
    if (last_win < 0) return 0;
    if (streak < BURST_MAX) return last_win;
    return 1 - last_win;
  endfunction

  task automatic model_reset();
    last_win    = -1;
    streak      = 0;
    exp_rsp_vld = 1'b0;
    exp_rsp_id  = 0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
  endtask

  task automatic rand_req(input int i);
    logic [7:0] idx;
    idx = 8'($urandom_range(0, 255));
    set_req(i, 1'($urandom_range(0, 1)), {22'd0, idx, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // One clock: check the DUT at the negedge against the model, then advance both.
  task automatic step_cycle();
    int g;
    logic [31:0] w;
    @(negedge clk);
    g = model_pick();
    last_g = g;
    obs_mem_we = mem_we; obs_mem_wstrb = mem_wstrb;
    obs_rsp0_v = rsp0_valid; obs_rsp0_d = rsp0_rdata;
    obs_rsp1_v = rsp1_valid; obs_rsp1_d = rsp1_rdata;
    check("ready0", {31'd0, req0_ready}, {31'd0, g == 0});
    check("ready1", {31'd0, req1_ready}, {31'd0, g == 1});
    check("mem_en", {31'd0, mem_en}, {31'd0, g >= 0});
    if (g >= 0) begin
      check("mem_we", {31'd0, mem_we}, {31'd0, req_we[g]});
      check("mem_addr", mem_addr, req_addr[g]);
      check("mem_wdata", mem_wdata, req_wdata[g]);
      check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, req_we[g] ? req_wstrb[g] : 4'b0000});
    end else begin
      check("idle_mem_addr", mem_addr, 32'd0);
      check("idle_mem_we", {31'd0, mem_we}, 32'd0);
    end
    check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, exp_rsp_vld && exp_rsp_id == 0});
    check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, exp_rsp_vld && exp_rsp_id == 1});
    if (exp_rsp_vld && exp_rsp_id == 0) check("rsp0_rdata", rsp0_rdata, exp_rsp_data);
    if (exp_rsp_vld && exp_rsp_id == 1) check("rsp1_rdata", rsp1_rdata, exp_rsp_data);
    exp_rsp_vld = (g >= 0);
    if (g >= 0) begin
      exp_rsp_id = g;
      w = ref_mem[req_addr[g][9:2]];
      if (req_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (req_wstrb[g][b]) w[8*b +: 8] = req_wdata[g][8*b +: 8];
        ref_mem[req_addr[g][9:2]] = w;
        exp_rsp_data = 32'd0;
      end else begin
        exp_rsp_data = w;
      end
      if (req_valid[1-g]) streak = (g == last_win) ? streak + 1 : 1;
      else streak = 0;
      last_win = g;
    end
    @(posedge clk);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_valid[0] || req_valid[1]) && n < 20) begin
      step_cycle();
      n++;
    end
    check("drain_bounded", {31'd0, req_valid[0] || req_valid[1]}, 32'd0);
    step_cycle();
  endtask

  initial begin
    int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int waited;
    logic got;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    env_mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 32'd0, 32'd0, 4'd0);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    mem_rdata = 32'd0;
    model_reset();

    // Reset held with both requesting: nothing may be granted.
    #2;
    rand_req(0); req_we[0] = 1'b0;
    rand_req(1); req_we[1] = 1'b0;
    @(negedge clk);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Contention from reset: req0 first, then alternating bursts of BURST_MAX.
    for (int k = 0; k < 12; k++) begin
      step_cycle();
      check("contention_grant", last_g, pat[k]);
      if (!req_valid[0]) rand_req(0);
      if (!req_valid[1]) rand_req(1);
    end

    // Reset asserted mid-cycle while an access is granted: the response is dropped.
    @(negedge clk);
    check("t1_mem_en_before", {31'd0, mem_en}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t1_ready0", {31'd0, req0_ready}, 32'd0);
    check("t1_ready1", {31'd0, req1_ready}, 32'd0);
    check("t1_mem_en", {31'd0, mem_en}, 32'd0);
    check("t1_mem_we", {31'd0, mem_we}, 32'd0);
    check("t1_mem_addr", mem_addr, 32'd0);
    check("t1_mem_wdata", mem_wdata, 32'd0);
    check("t1_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("t1_rsp0_rdata", rsp0_rdata, 32'd0);
    check("t1_rsp1_rdata", rsp1_rdata, 32'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    model_reset();
    @(negedge clk);
    check("t1_rsp0_dropped", {31'd0, rsp0_valid}, 32'd0);
    check("t1_rsp1_dropped", {31'd0, rsp1_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step_cycle();

    // Single read of preloaded word.
    set_req(0, 1'b0, 32'h40, 32'd0, 4'hF);
    step_cycle();
    check("t2_grant", last_g, 0);
    step_cycle();
    check("t2_rsp0_valid", {31'd0, obs_rsp0_v}, 32'd1);
    check("t2_rsp0_rdata", obs_rsp0_d, 32'hDEADBEEF);
    check("t2_rsp1_quiet", {31'd0, obs_rsp1_v}, 32'd0);

    // Partial write from the debug port, then read back through the core lane.
    set_req(1, 1'b1, 32'h80, 32'h12345678, 4'b0011);
    step_cycle();
    check("t3_mem_we", {31'd0, obs_mem_we}, 32'd1);
    check("t3_mem_wstrb", {28'd0, obs_mem_wstrb}, 32'h3);
    step_cycle();
    check("t3_rsp1_valid", {31'd0, obs_rsp1_v}, 32'd1);
    check("t3_rsp1_rdata", obs_rsp1_d, 32'd0);
    set_req(0, 1'b0, 32'h80, 32'd0, 4'd0);
    step_cycle();
    step_cycle();
    check("t3_readback", obs_rsp0_d, 32'h00005678);

    // Uncontested stream, then the debug port must get in within BURST_MAX+1 cycles.
    for (int k = 0; k < 10; k++) begin
      rand_req(0);
      step_cycle();
      check("t5_stream_grant", last_g, 0);
    end
    rand_req(1);
    waited = 0;
    got = 1'b0;
    for (int k = 0; k < BURST_MAX + 2 && !got; k++) begin
      if (!req_valid[0]) rand_req(0);
      step_cycle();
      waited++;
      if (last_g == 1) got = 1'b1;
    end
    check("t5_dbg_granted", {31'd0, got}, 32'd1);
    check("t5_dbg_wait", waited, BURST_MAX + 1);
    drain();

    // Random traffic on both ports.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 2) != 0) rand_req(i);
      step_cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
